// File: rtl/trap_redirect_if.sv
// Writeback-to-fetch trap/MRET redirect bus between the pipeline and trap_redirect_ctrl.
// Signal suffixes are from the controller's point of view.
interface trap_redirect_if;
    localparam int unsigned XLEN = 32;

    logic            wb_valid_insn_i;
    logic            wb_trap_valid_i;
    logic            wb_is_mret_i;
    logic [XLEN-1:0] trap_handler_addr_i;
    logic [XLEN-1:0] mepc_i;
    logic            redirect_ready_i;
    logic            flush_o;
    logic            stall_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [XLEN-1:0] trap_count_o;

    modport slave (
        input  wb_valid_insn_i, wb_trap_valid_i, wb_is_mret_i,
        input  trap_handler_addr_i, mepc_i, redirect_ready_i,
        output flush_o, stall_o, redirect_valid_o, redirect_pc_o, trap_count_o
    );

    modport master (
        output wb_valid_insn_i, wb_trap_valid_i, wb_is_mret_i,
        output trap_handler_addr_i, mepc_i, redirect_ready_i,
        input  flush_o, stall_o, redirect_valid_o, redirect_pc_o, trap_count_o
    );
endinterface

// File: rtl/trap_redirect_ctrl.sv
// Trap/MRET redirect controller: samples a writeback event in IDLE, flushes younger
// instructions for FLUSH_CYCLES cycles, then holds a redirect to fetch until accepted.
module trap_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    trap_redirect_if.slave  ctrl_if
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [XLEN-1:0]   trap_count_q, trap_count_d;
    logic              flush_q, flush_d;
    logic              stall_q, stall_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              trap_evt_c;
    logic              mret_evt_c;

    assign trap_evt_c = ctrl_if.wb_valid_insn_i & ctrl_if.wb_trap_valid_i;
    assign mret_evt_c = ctrl_if.wb_valid_insn_i & ctrl_if.wb_is_mret_i & ~ctrl_if.wb_trap_valid_i;

    // Next-state and registered-output decode; outputs follow the next state so they
    // line up with the state register.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        target_d     = target_q;
        trap_count_d = trap_count_q;

        case (state_q)
            ST_IDLE: begin
                if (trap_evt_c) begin
                    target_d     = ctrl_if.trap_handler_addr_i & ALIGN_MASK;
                    trap_count_d = trap_count_q + XLEN'(1);
                    flush_cnt_d  = CNT_W'(FLUSH_CYCLES - 1);
                    state_d      = ST_FLUSH;
                end else if (mret_evt_c) begin
                    target_d    = ctrl_if.mepc_i & ALIGN_MASK;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            ST_REDIRECT: begin
                if (ctrl_if.redirect_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        flush_d          = (state_d == ST_FLUSH);
        stall_d          = (state_d != ST_IDLE);
        redirect_valid_d = (state_d == ST_REDIRECT);
        redirect_pc_d    = redirect_valid_d ? target_d : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= '0;
            target_q         <= '0;
            trap_count_q     <= '0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            target_q         <= target_d;
            trap_count_q     <= trap_count_d;
            flush_q          <= flush_d;
            stall_q          <= stall_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign ctrl_if.flush_o          = flush_q;
    assign ctrl_if.stall_o          = stall_q;
    assign ctrl_if.redirect_valid_o = redirect_valid_q;
    assign ctrl_if.redirect_pc_o    = redirect_pc_q;
    assign ctrl_if.trap_count_o     = trap_count_q;
endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// Randomized plus directed bench for trap_redirect_ctrl against a cycle-offset reference model.
module tb_trap_redirect_ctrl;
    localparam int unsigned FC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trap_redirect_if bus ();

    trap_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ctrl_if (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an accepted event at edge m_ev makes cycle k = (edge - m_ev)
    // a flush cycle for 1..FC and a redirect cycle beyond FC until ready is seen.
    bit          m_busy   = 1'b0;
    int          m_ev     = 0;
    int          m_cyc    = 0;
    logic [31:0] m_target = '0;
    logic [31:0] m_count  = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic check_outputs();
        int  k;
        bit  e_flush, e_valid;
        k       = m_cyc - m_ev;
        e_flush = m_busy && (k <= int'(FC));
        e_valid = m_busy && (k > int'(FC));
        check_eq("flush",  32'(bus.flush_o),          32'(e_flush));
        check_eq("stall",  32'(bus.stall_o),          32'(m_busy));
        check_eq("rvalid", 32'(bus.redirect_valid_o), 32'(e_valid));
        check_eq("rpc",    bus.redirect_pc_o,         e_valid ? m_target : 32'h0);
        check_eq("tcount", bus.trap_count_o,          m_count);
    endtask

    task automatic model_edge();
        int k;
        k = m_cyc - m_ev;
        if (m_busy) begin
            if (k > int'(FC) && bus.redirect_ready_i) m_busy = 1'b0;
        end else if (bus.wb_valid_insn_i && bus.wb_trap_valid_i) begin
            m_busy   = 1'b1;
            m_ev     = m_cyc;
            m_target = bus.trap_handler_addr_i & ~32'h3;
            m_count  = m_count + 32'h1;
        end else if (bus.wb_valid_insn_i && bus.wb_is_mret_i) begin
            m_busy   = 1'b1;
            m_ev     = m_cyc;
            m_target = bus.mepc_i & ~32'h3;
        end
        m_cyc++;
    endtask

    task automatic drive(input bit v, input bit t, input bit m,
                         input logic [31:0] ha, input logic [31:0] ep, input bit rdy);
        bus.wb_valid_insn_i     = v;
        bus.wb_trap_valid_i     = t;
        bus.wb_is_mret_i        = m;
        bus.trap_handler_addr_i = ha;
        bus.mepc_i              = ep;
        bus.redirect_ready_i    = rdy;
    endtask

    // One cycle: check at the falling edge, drive, then advance the model at the rising edge.
    task automatic step(input bit v, input bit t, input bit m,
                        input logic [31:0] ha, input logic [31:0] ep, input bit rdy);
        @(negedge clk);
        check_outputs();
        drive(v, t, m, ha, ep, rdy);
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && m_busy; i++) idle_step(1'b1);
        check_eq("idle_timeout", 32'(m_busy), 32'h0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        check_outputs();
        #2 rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
        #1;
        check_eq("rst_flush",  32'(bus.flush_o),          32'h0);
        check_eq("rst_stall",  32'(bus.stall_o),          32'h0);
        check_eq("rst_rvalid", 32'(bus.redirect_valid_o), 32'h0);
        check_eq("rst_rpc",    bus.redirect_pc_o,         32'h0);
        check_eq("rst_tcount", bus.trap_count_o,          32'h0);
        m_busy   = 1'b0;
        m_count  = '0;
        m_target = '0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        rst_n = 1'b0;
        // Event held across reset release must be taken on the first live edge.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 1'b1);
        #1 check_outputs();
        #11 rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        wait_idle();

        // Trap, ready held high.
        step(1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 1'b1);
        for (int i = 0; i < int'(FC) + 2; i++) idle_step(1'b1);
        wait_idle();

        // MRET, ready low for several redirect cycles.
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h8000_0046, 1'b0);
        for (int i = 0; i < int'(FC) + 3; i++) idle_step(1'b0);
        idle_step(1'b1);
        idle_step(1'b0);
        wait_idle();

        // Trap and MRET together; trap wins.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 32'h8000_1000, 1'b0);
        // Second trap during flush and during redirect is ignored.
        step(1'b1, 1'b1, 1'b0, 32'h0000_0F00, 32'h0, 1'b0);
        for (int i = 0; i < int'(FC); i++) idle_step(1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0E00, 32'h0, 1'b0);
        // Back-to-back: transfer, then a new event on the very next IDLE cycle.
        idle_step(1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_4447, 1'b1);
        wait_idle();

        // Event with valid low is ignored.
        step(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        idle_step(1'b1);

        // Reset mid-redirect aborts the sequence.
        step(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b0);
        for (int i = 0; i < int'(FC) + 1; i++) idle_step(1'b0);
        async_reset();
        for (int i = 0; i < 6; i++) idle_step(1'b1);

        // Reset mid-flush.
        step(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b1);
        async_reset();
        for (int i = 0; i < 6; i++) idle_step(1'b1);

        // Trap counter wrap.
        wait_idle();
        #1 force dut.trap_count_q = 32'hFFFF_FFFF;
        #1 release dut.trap_count_q;
        m_count = 32'hFFFF_FFFF;
        step(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b1);
        wait_idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 40, $urandom, $urandom,
                 $urandom_range(0, 99) < 40);
        end
        wait_idle();
        idle_step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
